ram_loader: RTL and testbench

//   Write side of the 256x16 table memory. Accepts a stream of 16-bit words over
//   a valid/ready handshake and stores them at consecutive addresses from 0.
//   Has a registered random-access read port for downstream scan and compare

---
 rtl/ram_loader.sv | 89 ++++++++
 tb/tb_ram_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// Write side of the 256x16 table memory: streams words into consecutive addresses
// from 0 over a valid/ready handshake, with a registered random-access read port.
module ram_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   wr_count,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic              accept;

    logic [DATA_W-1:0] mem [DEPTH];

    assign in_ready = (state == LOAD);
    assign busy     = (state == LOAD);
    assign done     = (state == DONE);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            wr_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= LOAD;
                        wr_ptr   <= '0;
                        wr_count <= '0;
                    end
                end
                LOAD: begin
                    // A word arriving alongside stop is still stored and counted.
                    if (accept) begin
                        wr_ptr   <= wr_ptr + 1'b1;
                        wr_count <= wr_count + 1'b1;
                        if (wr_ptr == LAST_ADDR) begin
                            state <= DONE;
                        end
                    end
                    if (stop) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Non-blocking read of the array gives read-before-write on a colliding address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: a reference memory image tracks every accepted
// word and read results are checked through an expected-value queue.
module tb_ram_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic [8:0]  wr_count;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model [256];
    logic [15:0] sb [$];

    ram_loader #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_count (wr_count),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a);
        logic [15:0] e;
        rd_addr = a;
        sb.push_back(model[a]);
        step();
        e = sb.pop_front();
        chk($sformatf("rd[%0d]", a), 32'(rd_data), 32'(e));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        int cnt;
        int wr;
        logic [15:0] e;

        rst = 1'b0; start = 1'b0; stop = 1'b0;
        in_valid = 1'b0; in_data = '0; rd_addr = '0;
        step(); step();

        // Reset values
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_rd_data",  32'(rd_data),  32'd0);
        rst = 1'b1;
        in_valid = 1'b1; in_data = 16'hDEAD;
        step(); step();
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        chk("idle_wr_count", 32'(wr_count), 32'd0);
        in_valid = 1'b0;

        // Full load of 256 words
        pulse_start();
        in_valid = 1'b1;
        cnt = 0;
        while (in_ready && cnt < 300) begin
            in_data = 16'(cnt);
            if (cnt < 256) model[cnt] = 16'(cnt);
            step();
            cnt++;
        end
        in_valid = 1'b0;
        chk("full_ready_cycles", 32'(cnt), 32'd256);
        chk("full_done",     32'(done),     32'd1);
        chk("full_busy",     32'(busy),     32'd0);
        chk("full_wr_count", 32'(wr_count), 32'd256);
        for (int a = 0; a < 256; a++) rd(8'(a));

        // Gapped stream
        pulse_start();
        wr = 0;
        for (int n = 0; n < 16; n++) begin
            in_valid = (n % 2 == 0);
            in_data  = 16'hA5A5 + 16'(n);
            if (in_valid) begin
                model[wr] = in_data;
                wr++;
            end
            step();
        end
        in_valid = 1'b0;
        chk("gap_wr_count", 32'(wr_count), 32'd8);
        chk("gap_busy",     32'(busy),     32'd1);
        pulse_stop();
        chk("gap_done", 32'(done), 32'd1);
        for (int a = 0; a < 10; a++) rd(8'(a));

        // Early stop together with the 11th word
        pulse_start();
        in_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_data = 16'h3000 + 16'(i);
            model[i] = in_data;
            stop = (i == 10);
            step();
        end
        in_valid = 1'b0; stop = 1'b0;
        chk("stop_done",     32'(done),     32'd1);
        chk("stop_wr_count", 32'(wr_count), 32'd11);
        chk("stop_in_ready", 32'(in_ready), 32'd0);
        rd(8'd10);
        rd(8'd11);

        // Restart with start pulsed mid-session
        pulse_start();
        chk("restart_busy", 32'(busy), 32'd1);
        in_valid = 1'b1; in_data = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            model[i] = 16'hBEEF;
            step();
        end
        in_valid = 1'b0; start = 1'b0;
        step();
        chk("restart_wr_count", 32'(wr_count), 32'd3);
        chk("restart_busy2",    32'(busy),     32'd1);
        pulse_stop();
        chk("restart_done", 32'(done), 32'd1);
        for (int a = 0; a < 4; a++) rd(8'(a));

        // Read-during-write on address 5
        pulse_start();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 16'h0100 + 16'(i);
            model[i] = in_data;
            step();
        end
        in_data = 16'h1234; rd_addr = 8'd5;
        sb.push_back(model[5]);
        step();
        e = sb.pop_front();
        chk("rdw_old", 32'(rd_data), 32'(e));
        model[5] = 16'h1234;
        in_valid = 1'b0;
        sb.push_back(model[5]);
        step();
        e = sb.pop_front();
        chk("rdw_new", 32'(rd_data), 32'(e));
        pulse_stop();

        // Asynchronous reset in the middle of a load
        pulse_start();
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 16'h7770 + 16'(i);
            model[i] = in_data;
            step();
        end
        chk("mid_busy_before", 32'(busy), 32'd1);
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_busy",     32'(busy),     32'd0);
        chk("mid_rst_done",     32'(done),     32'd0);
        chk("mid_rst_wr_count", 32'(wr_count), 32'd0);
        chk("mid_rst_rd_data",  32'(rd_data),  32'd0);
        step();
        rst = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        rd(8'd0);
        rd(8'd1);
        rd(8'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
